memdados_arbiter: RTL and testbench
===================================

Name: memdados_arbiter

Overview:
- Two-requester access controller for the word-addressed data memory (memdados) in the MIPS core.
- Requester 0 is the CPU load/store unit; requester 1 is the debug/loader port that pre-fills and inspects data memory.
- Serialises accesses with round-robin fairness and drives the memory's address/dataWrite/memWrite/memRead pins.
- Returns registered read data with a per-requester ack pulse.

Parameters:
- MEM_WORDS, 256, memory depth in 32-bit words; only addr[31:2] < MEM_WORDS is in range.
- DATA_W, 32, data and address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low: reset==0 at a clk edge resets the block.
- req0  in  1  CPU request; held high until ack0.
- we0  in  1  CPU write(1)/read(0); stable while req0 is high.
- addr0  in  32  CPU byte address; stable while req0 is high.
- wdata0  in  32  CPU write data.
- ack0  out  1  one-cycle completion pulse to CPU.
- rdata0  out  32  CPU read data; valid when ack0=1 and we0=0.
- req1/we1/addr1/wdata1/ack1/rdata1: same as above for the debug port.
- mem_address  out  32  to memdados address.
- mem_dataWrite  out  32  to memdados dataWrite.
- mem_memWrite  out  1  to memdados memWrite.
- mem_memRead  out  1  to memdados memRead.
- mem_dataRead  in  32  from memdados dataRead (combinational read).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, DONE.
- IDLE -> ACCESS when any req is high. The winner is latched into `owner`.
  - Arbitration: if only one requester is requesting, that requester wins.
  - If both are requesting, the requester that is not `last_grant` wins.
  - `last_grant` resets to 1, so the CPU wins the first tie.
- ACCESS (1 cycle):
  - mem_address = latched addr; mem_dataWrite = latched wdata.
  - mem_memWrite = latched we; mem_memRead = !latched we.
  - For a read, mem_dataRead is captured into rdata_q at the end of the cycle.
  - `last_grant` <= owner.
  - Next state: DONE.
- DONE (1 cycle):
  - ack[owner] = 1; rdata[owner] = rdata_q.
  - The memory strobes are low.
  - Next state: IDLE.
- Latency: a req first seen high in IDLE at edge t gives ack at cycle t+2. Minimum spacing is 3 cycles per access.
- Requests are latched at the IDLE->ACCESS edge (addr, we, wdata). Changes after the latch are ignored until the next grant.
- The requester must drop req in the cycle after ack, or a new access starts. A req still high in IDLE is treated as a new request.
- The non-owner may raise or drop req at any time without effect on the current access.
- Outside ACCESS, mem_memWrite and mem_memRead are 0, and mem_address and mem_dataWrite hold their last values.
- rdata0/rdata1 hold their last delivered value. After a write, they are not updated.
- Reset values: state=IDLE, ack0=ack1=0, rdata0=rdata1=0, mem_memWrite=mem_memRead=0, mem_address=0, mem_dataWrite=0, busy=0, last_grant=1.
- Reset asserted mid-ACCESS: the write strobe drops at that edge. No ack is ever issued for the aborted access.
- Simultaneous request and ack on the same requester in DONE: the request is serviced only after the return to IDLE.

Optional Feature:
- Macro: MEMDADOS_ARB_CHECK_EN.
- With the macro defined:
  - In IDLE, the winner's request is validated. It is illegal if addr[1:0]!=0 or addr[31:2] >= MEM_WORDS.
  - An illegal request goes IDLE -> DONE directly with no memory strobe.
  - It pulses ack[owner] and err[owner] (extra outputs err0, err1, 1 bit each, reset 0). rdata is unchanged.
  - `last_grant` is still updated.
- Without the macro: no err ports. All addresses pass through unchanged; memdados truncates them.

Decomposition:
- Package memdados_arb_pkg:
  - State enum (IDLE, ACCESS, DONE).
  - Requester IDs REQ_CPU=0, REQ_DBG=1.
  - MEM_WORDS default.
- Sub-module rr_arb2: two-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational; used by the top in IDLE.

Test Plan:
- Reset held low 3 cycles, then release. All outputs are 0 and busy=0; no strobes appear.
- CPU write: req0, we0=1, addr0=0x10, wdata0=0xDEADBEEF. One ACCESS cycle shows mem_memWrite=1 and mem_address=0x10; ack0 follows 2 cycles after req. A debug read of 0x10 then returns rdata1=0xDEADBEEF.
- Tie: req0 and req1 asserted together as reads of 0x0 and 0x4 after reset. The CPU is served first (ack0 at t+2) and the debug port next (ack1 at t+5). With both kept requesting, grants alternate.
- Back-to-back: req0 held for 2 transactions at 0x8 and then 0xC. Acks come 3 cycles apart with correct data; ack1 never fires.
- Reset (low) asserted during ACCESS of a write of 0x55 to 0x20. No ack is issued, the state is IDLE next cycle, and rdata is 0.
- With MEMDADOS_ARB_CHECK_EN: addr0=0x402 gives ack0 and err0 at t+1, with mem_memWrite never high. addr0=0x400 (word 256) also gives err0.

Source files
------------

// File: rtl/memdados_arb_pkg.sv
// Shared definitions for the memdados two-requester access controller:
// FSM state encoding, requester IDs and the default memory depth.
package memdados_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_ACCESS = 2'd1;
  localparam arb_state_t ST_DONE   = 2'd2;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int MEM_WORDS_DEF = 256;

endpackage

// File: rtl/memdados_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, and on a tie
// the requester that was not granted last time wins.
module rr_arb2
  import memdados_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;

  always_comb begin
    gnt_id = REQ_CPU;
    case (req)
      2'b01:   gnt_id = REQ_CPU;
      2'b10:   gnt_id = REQ_DBG;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/memdados_arbiter.sv
// Serialises CPU (port 0) and debug (port 1) accesses to memdados.
// Define MEMDADOS_ARB_CHECK_EN to reject misaligned/out-of-range addresses via err0/err1.
module memdados_arbiter
  import memdados_arb_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int DATA_W    = 32
)
(
  input  logic              clk,
  input  logic              reset,
  // Handshake: reqN is held high with we/addr/wdata stable until ackN pulses
  // for one cycle; the requester must drop reqN in the cycle after ackN.
  input  logic              req0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
`ifdef MEMDADOS_ARB_CHECK_EN
  output logic              err0,
  output logic              err1,
`endif
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataWrite,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_dataRead,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  arb_state_t        state;
  logic              owner;
  logic              last_grant;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic              win_we;
  logic [DATA_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_bad;

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign win_we    = gnt_id ? we1    : we0;
  assign win_addr  = gnt_id ? addr1  : addr0;
  assign win_wdata = gnt_id ? wdata1 : wdata0;

`ifdef MEMDADOS_ARB_CHECK_EN
  logic err_q;
  assign win_bad = (win_addr[1:0] != 2'b00) ||
                   (win_addr[DATA_W-1:2] >= (DATA_W-2)'(MEM_WORDS));
`else
  assign win_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= REQ_CPU;
      last_grant <= REQ_DBG;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef MEMDADOS_ARB_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner <= gnt_id;
            if (win_bad) begin
              // Rejected requests skip the memory entirely but still rotate priority.
              state      <= ST_DONE;
              last_grant <= gnt_id;
`ifdef MEMDADOS_ARB_CHECK_EN
              err_q      <= 1'b1;
`endif
            end else begin
              state   <= ST_ACCESS;
              we_q    <= win_we;
              addr_q  <= win_addr;
              wdata_q <= win_wdata;
`ifdef MEMDADOS_ARB_CHECK_EN
              err_q   <= 1'b0;
`endif
            end
          end
        end
        ST_ACCESS: begin
          last_grant <= owner;
          if (!we_q) begin
            if (owner == REQ_DBG) rdata1_q <= mem_dataRead;
            else                  rdata0_q <= mem_dataRead;
          end
          state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Address/data are driven from the latch so they hold outside ACCESS.
  assign mem_address   = addr_q;
  assign mem_dataWrite = wdata_q;
  assign mem_memWrite  = (state == ST_ACCESS) &&  we_q;
  assign mem_memRead   = (state == ST_ACCESS) && !we_q;

  assign ack0   = (state == ST_DONE) && (owner == REQ_CPU);
  assign ack1   = (state == ST_DONE) && (owner == REQ_DBG);
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

`ifdef MEMDADOS_ARB_CHECK_EN
  assign err0 = ack0 && err_q;
  assign err1 = ack1 && err_q;
`endif

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_memdados_arbiter.sv
// Self-checking bench for memdados_arbiter with a memdados model and an
// expected-read-data scoreboard; MEMDADOS_ARB_CHECK_EN adds the err-path tests.
module tb_memdados_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, ack0, req1, we1, ack1;
  logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
  logic [31:0] mem_address, mem_dataWrite, mem_dataRead;
  logic        mem_memWrite, mem_memRead, busy;
  logic [1:0]  dbg_state;
`ifdef MEMDADOS_ARB_CHECK_EN
  logic        err0, err1;
`endif

  memdados_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req0          (req0),
    .we0           (we0),
    .addr0         (addr0),
    .wdata0        (wdata0),
    .ack0          (ack0),
    .rdata0        (rdata0),
    .req1          (req1),
    .we1           (we1),
    .addr1         (addr1),
    .wdata1        (wdata1),
    .ack1          (ack1),
    .rdata1        (rdata1),
`ifdef MEMDADOS_ARB_CHECK_EN
    .err0          (err0),
    .err1          (err1),
`endif
    .mem_address   (mem_address),
    .mem_dataWrite (mem_dataWrite),
    .mem_memWrite  (mem_memWrite),
    .mem_memRead   (mem_memRead),
    .mem_dataRead  (mem_dataRead),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memdados model: combinational read, write on rising edge
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  assign mem_dataRead = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_memWrite) mem[mem_address[9:2]] <= mem_dataWrite;

  // activity monitors
  int          wr_cnt, rd_cnt, ack0_cnt, ack1_cnt;
  logic [31:0] last_wr_addr, last_wr_data;
  always @(posedge clk) begin
    if (mem_memWrite) begin
      wr_cnt++;
      last_wr_addr = mem_address;
      last_wr_data = mem_dataWrite;
    end
    if (mem_memRead) rd_cnt++;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
  end

  // scoreboard
  logic [31:0] exp_q[$];
  logic        exp_port_q[$];
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive_req(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
  endtask

  // Counts rising edges until the port's ack is seen at a falling edge.
  task automatic wait_ack(input logic port, output int lat, output logic got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = port ? ack1 : ack0;
    end
  endtask

  // One complete transaction from a falling edge; leaves the bench at the ack's falling edge
  // with req dropped.
  task automatic run_access(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int exp_lat, input logic exp_err,
                            input string tag);
    int          lat;
    logic        got;
    logic [31:0] rd_before;
    rd_before = port ? rdata1 : rdata0;
    drive_req(port, we, addr, wdata);
    if (!exp_err) begin
      if (we) ref_mem[addr[9:2]] = wdata;
      else    exp_q.push_back(ref_mem[addr[9:2]]);
    end
    wait_ack(port, lat, got);
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
`ifdef MEMDADOS_ARB_CHECK_EN
    chk({tag, "_err"}, 32'(port ? err1 : err0), 32'(exp_err));
`endif
    if (port) req1 = 1'b0; else req0 = 1'b0;
    if (exp_err)
      chk({tag, "_rdata_hold"}, port ? rdata1 : rdata0, rd_before);
    else if (!we && exp_q.size() > 0)
      chk({tag, "_rdata"}, port ? rdata1 : rdata0, exp_q.pop_front());
  endtask

  initial begin
    int          lat, n, acks, a1_before, wr_before, rd_before;
    logic        got, pport;
    logic [31:0] v;

    checks = 0; errors = 0;
    wr_cnt = 0; rd_cnt = 0; ack0_cnt = 0; ack1_cnt = 0;
    last_wr_addr = '0; last_wr_data = '0;
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end

    // Reset held low for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {ack0, ack1, mem_memWrite, mem_memRead, busy}, 32'd0);
    chk("rst_rdata", rdata0 | rdata1, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_dataWrite, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", {busy, dbg_state}, 32'd0);
    chk("post_rst_strobes", 32'(wr_cnt + rd_cnt + ack0_cnt + ack1_cnt), 32'd0);

    // Tie after reset: CPU first, then alternate while both keep requesting
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1'b1, 1'b0, 32'h4, 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_port_q.push_back(k[0]);
      exp_q.push_back(k[0] ? ref_mem[1] : ref_mem[0]);
    end
    acks = 0; n = 0;
    while (acks < 4 && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack0 || ack1) begin
        pport = ack1;
        chk("tie_both_ack", 32'(ack0 && ack1), 32'd0);
        chk("tie_port", 32'(pport), 32'(exp_port_q.pop_front()));
        chk("tie_time", 32'(n), 32'(2 + 3 * acks));
        chk("tie_rdata", pport ? rdata1 : rdata0, exp_q.pop_front());
        acks++;
        if (acks == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    chk("tie_acks", 32'(acks), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    exp_q.delete();
    exp_port_q.delete();
    repeat (2) @(negedge clk);

    // CPU write then debug read-back
    wr_before = wr_cnt;
    run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 1'b0, "cpu_wr");
    chk("cpu_wr_strobes", 32'(wr_cnt - wr_before), 32'd1);
    chk("cpu_wr_addr", last_wr_addr, 32'h10);
    chk("cpu_wr_data", last_wr_data, 32'hDEADBEEF);
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 2, 1'b0, "dbg_rd");
    chk("dbg_rd_val", rdata1, 32'hDEADBEEF);
    @(negedge clk);

    // Randomised single accesses from either port
    for (int k = 0; k < 6; k++) begin
      run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 63)) << 2, $urandom, 2, 1'b0, "rnd");
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Back-to-back: req0 held across reads of 0x8 then 0xC
    a1_before = ack1_cnt;
    drive_req(1'b0, 1'b0, 32'h8, 32'h0);
    exp_q.push_back(ref_mem[2]);
    wait_ack(1'b0, lat, got);
    chk("b2b_lat0", 32'(lat), 32'd2);
    if (exp_q.size() > 0) chk("b2b_rdata0", rdata0, exp_q.pop_front());
    addr0 = 32'hC;
    exp_q.push_back(ref_mem[3]);
    wait_ack(1'b0, lat, got);
    chk("b2b_spacing", 32'(lat), 32'd3);
    req0 = 1'b0;
    if (exp_q.size() > 0) chk("b2b_rdata1", rdata0, exp_q.pop_front());
    repeat (3) @(negedge clk);
    chk("b2b_no_ack1", 32'(ack1_cnt - a1_before), 32'd0);

    // Reset asserted during the ACCESS cycle of a write
    a1_before = ack0_cnt;
    drive_req(1'b0, 1'b1, 32'h20, 32'h55);
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_access", {dbg_state, mem_memWrite}, {30'd0, 2'd1, 1'b1} >> 0);
    reset = 1'b0;
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_state", {busy, dbg_state, mem_memWrite}, 32'd0);
    chk("abort_rdata", rdata0, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_ack", 32'(ack0_cnt - a1_before), 32'd0);

`ifdef MEMDADOS_ARB_CHECK_EN
    // Illegal addresses: misaligned and word 256
    wr_before = wr_cnt;
    rd_before = rd_cnt;
    run_access(1'b0, 1'b1, 32'h402, 32'h1234, 1, 1'b1, "err_misalign");
    @(negedge clk);
    run_access(1'b0, 1'b0, 32'h400, 32'h0, 1, 1'b1, "err_range");
    chk("err_no_strobe", 32'((wr_cnt - wr_before) + (rd_cnt - rd_before)), 32'd0);
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'h3FC, 32'h0, 2, 1'b0, "last_word");
    @(negedge clk);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
